// File: rtl/ternary_conv2d_stream.sv
// ternary_conv2d_stream: streaming valid-mode KxK convolution with ternary weights, all filters in parallel
module ternary_conv2d_stream #(
  parameter int DATA_W   = 9,
  parameter int IMG_W    = 5,
  parameter int IMG_H    = 5,
  parameter int K        = 3,
  parameter int NUM_FILT = 2,
  parameter int ACC_W    = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [2*NUM_FILT-1:0]        w_data,
  input  logic                         reload_w,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_W-1:0]     pix_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FILT*ACC_W-1:0]    out_data,
  output logic [7:0]                   out_row,
  output logic [7:0]                   out_col,
  output logic                         frame_done
);
  localparam int NT    = K * K;
  localparam int TW    = $clog2(NT);
  localparam int DEPTH = (K - 1) * IMG_W + K;
  localparam int RAW_W = DATA_W + $clog2(NT);
  localparam int SUM_W = RAW_W > ACC_W ? RAW_W : ACC_W;
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MINV = ~MAXV;
  localparam logic [7:0]    LAST_C = 8'(IMG_W - 1);
  localparam logic [7:0]    LAST_R = 8'(IMG_H - 1);
  localparam logic [7:0]    KM1    = 8'(K - 1);
  localparam logic [TW-1:0] LAST_T = TW'(NT - 1);

  typedef enum logic {S_WLOAD, S_RUN} state_t;
  state_t state_q, state_d;

  logic [2*NUM_FILT-1:0]     w_q [NT];
  logic [TW-1:0]             t_q;
  logic [7:0]                row_q, col_q, out_row_q, out_col_q;
  logic signed [DATA_W-1:0]  lb_q [DEPTH-1];
  logic signed [DATA_W-1:0]  win [DEPTH];
  logic signed [SUM_W-1:0]   acc [NUM_FILT];
  logic [NUM_FILT*ACC_W-1:0] res, out_data_q;
  logic                      out_valid_q, accept, emit, hs, reload_take, w_take;

  assign w_take      = state_q == S_WLOAD && w_valid;
  assign reload_take = state_q == S_RUN && reload_w && row_q == 8'd0 && col_q == 8'd0 && !out_valid_q;
  assign hs          = out_valid_q && out_ready;
  assign w_ready     = state_q == S_WLOAD;
  assign pix_ready   = state_q == S_RUN && !reload_take && (!out_valid_q || out_ready);
  assign accept      = pix_valid && pix_ready;
  assign emit        = accept && row_q >= KM1 && col_q >= KM1;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign frame_done  = hs && out_row_q == 8'(IMG_H - K) && out_col_q == 8'(IMG_W - K);

  always_comb begin
    state_d = (w_take && t_q == LAST_T) ? S_RUN : reload_take ? S_WLOAD : state_q;
  end

  // win[0] is the incoming pixel; win[n] is the pixel accepted n pixels earlier
  always_comb begin
    win[0] = pix_data;
    for (int i = 1; i < DEPTH; i++) win[i] = lb_q[i-1];
  end

  always_comb begin
    res = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      acc[f] = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          acc[f] = acc[f] + (w_q[i*K+j][2*f +: 2] == 2'b01 ?  SUM_W'(win[(K-1-i)*IMG_W + K-1-j]) :
                             w_q[i*K+j][2*f +: 2] == 2'b11 ? -SUM_W'(win[(K-1-i)*IMG_W + K-1-j]) : '0);
      res[f*ACC_W +: ACC_W] = ACC_W'(acc[f] > MAXV ? MAXV : acc[f] < MINV ? MINV : acc[f]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WLOAD;
      t_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      for (int i = 0; i < NT; i++) w_q[i] <= '0;
      for (int i = 0; i < DEPTH - 1; i++) lb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (w_take) begin
        w_q[t_q] <= w_data;
        t_q      <= t_q == LAST_T ? '0 : t_q + TW'(1);
      end
      if (reload_take) for (int i = 0; i < NT; i++) w_q[i] <= '0;
      if (accept) begin
        lb_q[0] <= pix_data;
        for (int i = 1; i < DEPTH - 1; i++) lb_q[i] <= lb_q[i-1];
        col_q <= col_q == LAST_C ? '0 : col_q + 8'd1;
        row_q <= col_q != LAST_C ? row_q : row_q == LAST_R ? '0 : row_q + 8'd1;
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        out_row_q   <= row_q - KM1;
        out_col_q   <= col_q - KM1;
      end else if (hs) out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ternary_conv2d_stream.sv
// tb_ternary_conv2d_stream: randomized and directed checks of ternary_conv2d_stream against a window-sum model
module tb_ternary_conv2d_stream;
  localparam int DW = 9, IW = 5, IH = 5, KK = 3, NF = 2, AW = 12;

  logic clk = 1'b0, reset = 1'b1, w_valid = 1'b0, reload_w = 1'b0, pix_valid = 1'b0, out_ready = 1'b1;
  logic [2*NF-1:0] w_data = '0;
  logic signed [DW-1:0] pix_data = '0;
  logic w_ready, pix_ready, out_valid, frame_done;
  logic [NF*AW-1:0] out_data;
  logic [7:0] out_row, out_col;

  ternary_conv2d_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .NUM_FILT(NF), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .reload_w(reload_w),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct {int d0; int d1; int row; int col; bit last;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int log0[$], log1[$];
  int n_chk = 0, n_fail = 0, fd_cnt = 0, fd_at = -1, rdy_mode = 0, bp_to;
  bit lat_pending = 1'b0, lat_exp = 1'b0;
  logic [NF*AW-1:0] held;
  logic [1:0] wc [NF][KK*KK];
  int img [IH][IW];
  int lit1 [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wdec(input logic [1:0] c);
    return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
  endfunction

  function automatic int sat(input int v);
    int hi = (1 << (AW - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction

  // Every valid window, top-left anchored, in raster order.
  task automatic model_frame();
    for (int r = 0; r <= IH - KK; r++)
      for (int c = 0; c <= IW - KK; c++) begin
        exp_t e;
        int s0 = 0, s1 = 0;
        for (int i = 0; i < KK; i++)
          for (int j = 0; j < KK; j++) begin
            s0 += img[r+i][c+j] * wdec(wc[0][i*KK+j]);
            s1 += img[r+i][c+j] * wdec(wc[1][i*KK+j]);
          end
        e.d0 = sat(s0); e.d1 = sat(s1); e.row = r; e.col = c;
        e.last = (r == IH - KK) && (c == IW - KK);
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (lat_pending) begin
        chk("latency_out_valid", out_valid, lat_exp);
        lat_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          cur = exp_q.pop_front();
          chk("out_f0", $signed(out_data[AW-1:0]), cur.d0);
          chk("out_f1", $signed(out_data[2*AW-1:AW]), cur.d1);
          chk("out_row", out_row, cur.row);
          chk("out_col", out_col, cur.col);
          chk("frame_done", frame_done, cur.last);
          log0.push_back($signed(out_data[AW-1:0]));
          log1.push_back($signed(out_data[2*AW-1:AW]));
          if (frame_done) begin fd_cnt++; fd_at = log0.size(); end
        end
      end else chk("frame_done_idle", frame_done, 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    pix_valid = 0; w_valid = 0; reload_w = 0; reset = 1;
    @(posedge clk); #1;
    exp_q.delete(); lat_pending = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_w_ready", w_ready, 1);
    chk("rst_pix_ready", pix_ready, 0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic load_w();
    for (int t = 0; t < KK*KK; t++) begin
      bit ok;
      int to = 0;
      w_valid = 1; w_data = {wc[1][t], wc[0][t]};
      do begin @(negedge clk); ok = w_ready; @(posedge clk); #1; to++; end while (!ok && to < 50);
      if (!ok) chk("w_load_timeout", 0, 1);
    end
    w_valid = 0;
    @(negedge clk);
    chk("w_ready_after_load", w_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_pix(input int v, input bit lat, input bit emit);
    bit ok;
    int to = 0;
    pix_valid = 1; pix_data = v[DW-1:0];
    do begin @(negedge clk); ok = pix_ready; @(posedge clk); #1; to++; end while (!ok && to < 500);
    pix_valid = 0;
    if (!ok) chk("pix_timeout", 0, 1);
    else if (lat) begin lat_exp = emit; lat_pending = 1; end
  endtask

  task automatic send_frame(input int gapmax, input bit lat, input int npix, input int rlo, input int rhi);
    if (npix == IH*IW) model_frame();
    for (int idx = 0; idx < npix; idx++) begin
      int g = int'($urandom_range(0, gapmax));
      repeat (g) begin @(posedge clk); #1; end
      reload_w = idx >= rlo && idx <= rhi;
      send_pix(img[idx/IW][idx%IW], lat, (idx/IW >= KK-1) && (idx%IW >= KK-1));
    end
    reload_w = 0;
  endtask

  task automatic drain();
    int to = 0;
    while (exp_q.size() != 0 && to < 3000) begin @(posedge clk); to++; end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reload();
    reload_w = 1;
    @(posedge clk); #1;
    reload_w = 0;
    @(negedge clk);
    chk("reload_w_ready", w_ready, 1);
    chk("reload_pix_ready", pix_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic clr();
    log0.delete(); log1.delete(); fd_cnt = 0; fd_at = -1;
  endtask

  task automatic set_basic();
    for (int t = 0; t < KK*KK; t++) begin
      wc[0][t] = t % KK == 0 ? 2'b01 : t % KK == KK-1 ? 2'b11 : 2'b00;
      wc[1][t] = t == 4 ? 2'b01 : 2'b00;
    end
  endtask

  task automatic set_all(input logic [1:0] code);
    for (int t = 0; t < KK*KK; t++) begin wc[0][t] = code; wc[1][t] = code; end
  endtask

  task automatic set_img(input int mode, input int v);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = mode == 0 ? r*IW + c : mode == 1 ? v : int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic check_ramp_basic(input string tag);
    chk({tag, "_count"}, log1.size(), 9);
    for (int k = 0; k < log1.size(); k++) begin
      chk({tag, "_f1_lit"}, log1[k], lit1[k]);
      chk({tag, "_f0_lit"}, log0[k], -6);
    end
    chk({tag, "_fd_count"}, fd_cnt, 1);
    chk({tag, "_fd_at"}, fd_at, 9);
  endtask

  initial begin
    do_reset();

    set_basic(); load_w(); set_img(0, 0); clr();
    send_frame(0, 1, 25, -1, -1); drain();
    check_ramp_basic("basic");

    do_reload(); set_all(2'b01); load_w(); set_img(1, 255); clr();
    send_frame(0, 0, 25, -1, -1); drain();
    chk("sat_pos_f0", log0.size() > 0 ? log0[0] : 0, 2047);
    chk("sat_pos_f1", log1.size() > 0 ? log1[0] : 0, 2047);

    do_reload(); set_all(2'b11); load_w(); clr();
    send_frame(0, 0, 25, -1, -1); drain();
    chk("sat_neg_f0", log0.size() > 0 ? log0[0] : 0, -2048);

    do_reload(); set_basic(); load_w(); set_img(0, 0); clr();
    rdy_mode = 2;
    fork
      send_frame(0, 0, 25, -1, -1);
      begin
        bp_to = 0;
        while (out_valid !== 1'b1 && bp_to < 200) begin @(negedge clk); bp_to++; end
        chk("bp_seen_valid", out_valid, 1);
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          chk("bp_pix_ready", pix_ready, 0);
          chk("bp_valid_hold", out_valid, 1);
          chk("bp_data_stable", int'(out_data == held), 1);
        end
        rdy_mode = 0;
      end
    join
    drain();
    check_ramp_basic("bp");

    clr();
    send_frame(0, 0, 25, 12, 20); drain();
    check_ramp_basic("midreload");
    @(negedge clk);
    chk("midreload_w_ready", w_ready, 0);
    @(posedge clk); #1;
    do_reload();

    for (int t = 0; t < KK*KK; t++) begin
      wc[0][t] = 2'($urandom_range(0, 3));
      wc[1][t] = 2'($urandom_range(0, 3));
    end
    load_w(); clr(); rdy_mode = 1;
    for (int fr = 0; fr < 3; fr++) begin
      set_img(2, 0);
      send_frame(2, 0, 25, -1, -1);
    end
    drain(); rdy_mode = 0;
    @(posedge clk); #1;
    chk("rand_count", log0.size(), 27);
    chk("rand_fd_count", fd_cnt, 3);

    do_reload(); set_all(2'b10); load_w(); set_img(2, 0); clr();
    send_frame(1, 0, 25, -1, -1); drain();
    for (int k = 0; k < log0.size(); k++) begin
      chk("reserved_f0_zero", log0[k], 0);
      chk("reserved_f1_zero", log1[k], 0);
    end

    do_reload(); set_basic(); load_w(); set_img(0, 0); clr();
    send_frame(0, 0, 12, -1, -1);
    do_reset();
    load_w(); clr();
    send_frame(0, 1, 25, -1, -1); drain();
    check_ramp_basic("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ternary_conv2d_stream.md
Name: ternary_conv2d_stream

Overview:
- Streaming, multiplier-free 2-D convolution engine for ternary-weight CNN layers. Generalises the fixed 5x5-image, 3x3-kernel, two-filter comparator convolution to parametrised image size, pixel width and filter count.
- Pixels arrive in raster order over a valid/ready stream and are held in internal line buffers. All filters are evaluated in parallel per window using add/subtract/skip selection (weight +1/-1/0).
- Sits between the activation source (frame memory or the previous layer) and the next layer or pooling stage.

Parameters:
- DATA_W, 9: signed pixel width.
- IMG_W, 5: image width in pixels (>= K).
- IMG_H, 5: image height in pixels (>= K).
- K, 3: kernel size (square). Valid-mode convolution, stride 1, no padding.
- NUM_FILT, 2: number of filters computed in parallel.
- ACC_W, 12: signed output width, saturating.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- w_valid  in  1  weight tap valid
- w_ready  out  1  high only in S_WLOAD
- w_data  in  2*NUM_FILT  one kernel tap for all filters; filter f at [2f+1:2f]; 01=+1, 11=-1, 00=0, 10=0 (reserved)
- reload_w  in  1  request return to weight load
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
- pix_data  in  DATA_W  signed pixel, raster order
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  NUM_FILT*ACC_W  filter f at [f*ACC_W +: ACC_W], signed
- out_row  out  8  output row index, 0..IMG_H-K
- out_col  out  8  output column index, 0..IMG_W-K
- frame_done  out  1  one-cycle pulse when the last output of a frame handshakes

Behaviour:
- Reset (synchronous, highest priority, legal mid-frame):
  - State -> S_WLOAD; all weights -> 0; tap counter, pixel row/col counters and line buffers cleared.
  - out_valid=0, out_data=0, out_row=0, out_col=0, frame_done=0, pix_ready=0, w_ready=1.
  - Any partially received frame is discarded.
- S_WLOAD:
  - Each w_valid&&w_ready writes tap t (t=0..K*K-1, raster order: t=row*K+col) and increments t.
  - After tap K*K-1 is written -> S_RUN next cycle, t reset to 0.
  - pix_ready=0. reload_w is ignored.
- S_RUN:
  - pix_ready = !out_valid || out_ready (one-entry output register).
  - On each accepted pixel at image position (r,c): shift it into the window/line buffers and advance c, wrapping to r+1 at IMG_W-1.
  - If r>=K-1 and c>=K-1, the next cycle asserts out_valid with out_row=r-K+1, out_col=c-K+1. Latency is 1 cycle from pixel acceptance to out_valid.
  - out_data[f] = sum of window pixels with weight +1 minus sum of window pixels with weight -1 (codes 00 and 10 contribute 0). Accumulate at full precision (DATA_W+ceil(log2(K*K)) bits), then saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - out_valid holds, and out_data/out_row/out_col stay stable, until out_ready. Cleared on handshake unless a new result loads the same cycle.
  - After pixel (IMG_H-1, IMG_W-1) is accepted, counters wrap to (0,0); the next frame uses the same weights. frame_done pulses on the handshake of output (IMG_H-K, IMG_W-K).
  - reload_w is honoured only when the pixel counters are (0,0) and out_valid=0: -> S_WLOAD, weights cleared. Otherwise it is ignored; it is not latched.
- Simultaneous output handshake and new result: the new result loads and out_valid stays 1. No bubble is required.
- Weight changes are impossible mid-frame.

Test Plan:
- Reset: assert reset 2 cycles mid-activity -> out_valid=0, out_data=0, out_row/out_col=0, frame_done=0, w_ready=1, pix_ready=0.
- Basic conv (defaults):
  - Filter0 taps [+1,0,-1,+1,0,-1,+1,0,-1]; filter1 only tap 4 = +1.
  - Stream pixels p=r*5+c with no stalls.
  - Expect 9 outputs, each 1 cycle after pixels 12,13,14,17,18,19,22,23,24.
  - filter0 = -6 every time; filter1 = 6,7,8,11,12,13,16,17,18.
  - (row,col) advances (0,0)..(2,2); frame_done on the 9th handshake.
- Saturation: all pixels 255, all taps +1 -> filter0 = 2047 (raw 2295). All taps -1 -> -2048.
- Backpressure:
  - Hold out_ready=0 from the first out_valid for 5 cycles -> pix_ready=0 and out_data stable throughout.
  - Release -> all 9 outputs delivered in order with none lost or duplicated.
- Mid-frame control: reload_w after 12 pixels -> ignored, frame completes normally. reload_w after frame_done -> S_WLOAD, w_ready=1, pix_ready=0.
- Reserved code and reset mid-frame:
  - Taps all 2'b10 -> outputs 0.
  - Reset after 12 pixels -> S_WLOAD, weights 0.
  - After reloading weights, the full frame from pixel 0 gives outputs matching the basic-conv case.
